// File: rtl/key_sw_debounce_pkg.sv
// Shared constants for the key/switch input-conditioning stage.
// Defaults assume a 50 MHz lb_clk sampled at 1 kHz.
package key_sw_debounce_pkg;

  localparam int unsigned LB_CLK_HZ = 50_000_000;
  localparam int unsigned SAMPLE_HZ = 1_000;

  localparam int unsigned N_KEY_DEF = 4;
  localparam int unsigned N_SW_DEF  = 3;

  localparam int unsigned TICK_DIV_DEF       = LB_CLK_HZ / SAMPLE_HZ;
  localparam int unsigned DEBOUNCE_TICKS_DEF = 20;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_sw_debounce_chan.sv
// One debounced input: 2-flop synchroniser, tick-driven run counter,
// stable level flop and registered edge pulses.
module debounce_chan
  import key_sw_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter logic        RESET_VAL      = 1'b0
) (
  input  logic lb_clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pad,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic change
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          meta;
  logic          synced;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          accept;

  assign differ = synced ^ clean;
  assign accept = differ & tick & (cnt == LAST);

  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= RESET_VAL;
      synced <= RESET_VAL;
      clean  <= RESET_VAL;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      change <= 1'b0;
    end else begin
      meta   <= pad;
      synced <= meta;
      rise   <= accept & synced;
      fall   <= accept & ~synced;
      change <= accept;
      // any sample matching the stable level restarts the window
      if (!differ) begin
        cnt <= '0;
      end else if (tick) begin
        if (accept) begin
          clean <= synced;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/key_sw_debounce.sv
// Key/switch conditioning: shared sample prescaler feeding one
// debounce channel per pad; outputs keep raw pad polarity.
module key_sw_debounce
  import key_sw_debounce_pkg::*;
#(
  parameter int unsigned N_KEY          = N_KEY_DEF,
  parameter int unsigned N_SW           = N_SW_DEF,
  parameter int unsigned TICK_DIV       = TICK_DIV_DEF,
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic             lb_clk,
  input  logic             rst_n,
  input  logic [N_KEY-1:0] key_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_KEY-1:0] key_clean,
  output logic [N_SW-1:0]  sw_clean,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release,
  output logic [N_SW-1:0]  sw_change
);

  localparam int unsigned PW = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PMAX);

  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  logic [N_KEY-1:0] key_chg_unused;
  logic [N_SW-1:0]  sw_rise_unused;
  logic [N_SW-1:0]  sw_fall_unused;

  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    debounce_chan #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .RESET_VAL     (1'b1)
    ) u_chan (
      .lb_clk(lb_clk),
      .rst_n (rst_n),
      .tick  (tick),
      .pad   (key_raw[i]),
      .clean (key_clean[i]),
      .rise  (key_release[i]),
      .fall  (key_press[i]),
      .change(key_chg_unused[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_chan #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .RESET_VAL     (1'b0)
    ) u_chan (
      .lb_clk(lb_clk),
      .rst_n (rst_n),
      .tick  (tick),
      .pad   (sw_raw[i]),
      .clean (sw_clean[i]),
      .rise  (sw_rise_unused[i]),
      .fall  (sw_fall_unused[i]),
      .change(sw_change[i])
    );
  end

endmodule

// File: tb/tb_key_sw_debounce.sv
// Bench: two configurations (4/3 and 1/1) checked every cycle against
// a history-window model, plus directed latency/pulse checks.
module tb_key_sw_debounce;

  localparam logic [6:0] RSTV = 7'b000_1111;
  localparam int MAXH = 8192;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_raw = 4'h0;
  logic [2:0] sw_raw = 3'h7;

  logic [3:0] kc0, kp0, kr0, kc1, kp1, kr1;
  logic [2:0] sc0, sch0, sc1, sch1;

  always #5 clk = ~clk;

  key_sw_debounce #(
    .N_KEY(4), .N_SW(3), .TICK_DIV(4), .DEBOUNCE_TICKS(3)
  ) u0 (
    .lb_clk(clk), .rst_n(rst_n),
    .key_raw(key_raw), .sw_raw(sw_raw),
    .key_clean(kc0), .sw_clean(sc0),
    .key_press(kp0), .key_release(kr0),
    .sw_change(sch0)
  );

  key_sw_debounce #(
    .N_KEY(4), .N_SW(3), .TICK_DIV(1), .DEBOUNCE_TICKS(1)
  ) u1 (
    .lb_clk(clk), .rst_n(rst_n),
    .key_raw(key_raw), .sw_raw(sw_raw),
    .key_clean(kc1), .sw_clean(sc1),
    .key_press(kp1), .key_release(kr1),
    .sw_change(sch1)
  );

  logic [6:0] cl[2];
  logic [6:0] pf[2];
  logic [6:0] pr[2];
  assign cl[0] = {sc0, kc0};
  assign cl[1] = {sc1, kc1};
  assign pf[0] = {sch0, kp0};
  assign pf[1] = {sch1, kp1};
  assign pr[0] = {sch0, kr0};
  assign pr[1] = {sch1, kr1};

  int vectors = 0;
  int errs = 0;
  int nprint = 0;
  int press1_cnt = 0;

  // model: a level is accepted on a tick edge when the synced pad has
  // disagreed with the settled level over the last DEBOUNCE_TICKS ticks
  int td[2] = '{4, 1};
  int dt[2] = '{3, 1};
  int ne[2];
  logic [6:0] pad_h[2][MAXH];
  logic [6:0] cl_h[2][MAXH];
  logic [6:0] exp_cl[2];
  logic [6:0] exp_ri[2];
  logic [6:0] exp_fa[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ne[i] = 0;
      exp_cl[i] = RSTV;
      exp_ri[i] = '0;
      exp_fa[i] = '0;
    end
  endtask

  function automatic bit accepted(int i, int e, int ch);
    logic c;
    logic [6:0] s;
    logic [6:0] h;
    int ticks;
    ticks = 0;
    if (e % td[i] != 0) return 1'b0;
    h = cl_h[i][e-1];
    c = h[ch];
    for (int j = e; j >= 1; j--) begin
      s = (j >= 3) ? pad_h[i][j-3] : RSTV;
      h = cl_h[i][j-1];
      if (s[ch] == c || h[ch] != c) return 1'b0;
      if (j % td[i] == 0) ticks++;
      if (ticks == dt[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_edge(int i, logic [6:0] pad);
    logic [6:0] acc;
    int e;
    e = ne[i] + 1;
    if (e > MAXH) e = MAXH;
    ne[i] = e;
    pad_h[i][e-1] = pad;
    cl_h[i][e-1] = exp_cl[i];
    acc = '0;
    for (int ch = 0; ch < 7; ch++) acc[ch] = accepted(i, e, ch);
    exp_cl[i] = exp_cl[i] ^ acc;
    exp_ri[i] = acc & exp_cl[i];
    exp_fa[i] = acc & ~exp_cl[i];
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else for (int i = 0; i < 2; i++) model_edge(i, {sw_raw, key_raw});
  end

  logic [18:0] got, want;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      got  = {cl[i], pf[i][3:0], pr[i][3:0], pf[i][6:4]};
      want = {exp_cl[i], exp_fa[i][3:0], exp_ri[i][3:0],
              exp_ri[i][6:4] | exp_fa[i][6:4]};
      vectors++;
      if (got !== want) begin
        errs++;
        if (nprint < 30) begin
          nprint++;
          $display("FAIL cycle u%0d t=%0t: got %h required %h",
                   i, $time, got, want);
        end
      end
    end
    press1_cnt += int'(kp0[1]);
  end

  task automatic chk(input string nm, input bit ok, input int act,
                     input string req);
    vectors++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %0d, required %s", nm, act, req);
    end
  endtask

  task automatic drv_pt();
    @(posedge clk);
    #2;
  endtask

  task automatic meas(input string nm, input int ch, input logic lvl,
                      input int lo, input int hi, input bit use1);
    int n0, n1;
    bit p0, p1;
    logic [6:0] v;
    n0 = 0; n1 = 0; p0 = 0; p1 = 0;
    for (int n = 1; n <= 30 && (n0 == 0 || (use1 && n1 == 0)); n++) begin
      @(posedge clk);
      @(negedge clk);
      v = cl[0];
      if (n0 == 0 && v[ch] == lvl) begin
        n0 = n;
        v = lvl ? pr[0] : pf[0];
        p0 = v[ch];
      end
      v = cl[1];
      if (n1 == 0 && v[ch] == lvl) begin
        n1 = n;
        v = lvl ? pr[1] : pf[1];
        p1 = v[ch];
      end
    end
    chk({nm, "_lat"}, n0 >= lo && n0 <= hi, n0,
        $sformatf("%0d..%0d", lo, hi));
    chk({nm, "_pulse"}, p0, int'(p0), "1");
    if (use1) begin
      chk({nm, "_lat_td1"}, n1 == 3, n1, "3");
      chk({nm, "_pulse_td1"}, p1, int'(p1), "1");
    end
  endtask

  initial begin
    int n0, n1, bad;
    bit p0;
    logic [6:0] pad7;
    bit noisy;
    model_reset();

    repeat (4) @(negedge clk);
    chk("rst_key_clean", kc0 == 4'hF && kc1 == 4'hF, int'(kc0), "15");
    chk("rst_sw_clean", sc0 == 3'h0 && sc1 == 3'h0, int'(sc0), "0");
    chk("rst_pulses", {kp0, kr0, sch0, kp1, kr1, sch1} == '0,
        int'({kp0, kr0, sch0}), "0");

    drv_pt();
    rst_n = 1'b1;
    n0 = 0; n1 = 0; p0 = 0;
    for (int n = 1; n <= 20 && n0 == 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n1 == 0 && kc1 == 4'h0) n1 = n;
      if (kc0 == 4'h0) begin
        n0 = n;
        p0 = (kp0 == 4'hF) && (sch0 == 3'h7) && (sc0 == 3'h7);
      end
    end
    chk("rel_lat", n0 == 12, n0, "12");
    chk("rel_lat_td1", n1 == 3, n1, "3");
    chk("rel_pulses", p0, int'(p0), "1");
    @(negedge clk);
    chk("rel_pulse_end", kp0 == 4'h0 && sch0 == 3'h0, int'(kp0), "0");

    drv_pt();
    key_raw = 4'hF;
    sw_raw = 3'h0;
    repeat (30) drv_pt();
    key_raw[0] = 1'b0;
    meas("press0", 0, 1'b0, 11, 14, 1'b1);
    repeat (20) drv_pt();
    key_raw[0] = 1'b1;
    meas("release0", 0, 1'b1, 11, 14, 1'b1);

    repeat (20) drv_pt();
    press1_cnt = 0;
    bad = 0;
    key_raw[1] = 1'b0;
    repeat (6) begin
      drv_pt();
      if (kc0[1] !== 1'b1) bad++;
    end
    key_raw[1] = 1'b1;
    drv_pt();
    if (kc0[1] !== 1'b1) bad++;
    key_raw[1] = 1'b0;
    meas("bounce1", 1, 1'b0, 11, 14, 1'b0);
    repeat (20) drv_pt();
    chk("bounce_early", bad == 0, bad, "0");
    chk("bounce_one_press", press1_cnt == 1, press1_cnt, "1");

    bad = 0;
    sw_raw[2] = 1'b1;
    repeat (7) drv_pt();
    sw_raw[2] = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (sc0[2] !== 1'b0 || sch0 !== 3'h0) bad++;
      drv_pt();
    end
    chk("glitch_sw2", bad == 0, bad, "0");

    key_raw = 4'hF;
    repeat (20) drv_pt();
    key_raw = 4'h0;
    sw_raw = 3'h5;
    n0 = 0;
    for (int n = 1; n <= 20 && n0 == 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (kp0 != 4'h0 || sch0 != 3'h0) n0 = n;
    end
    chk("simul_seen", n0 != 0, n0, "1..20");
    chk("simul_pulses", kp0 == 4'hF && sch0 == 3'h5,
        int'({kp0, sch0}), $sformatf("%0d", {4'hF, 3'h5}));

    drv_pt();
    key_raw = 4'hF;
    sw_raw = 3'h0;
    repeat (20) drv_pt();
    key_raw = 4'hE;
    repeat (8) drv_pt();
    rst_n = 1'b0;
    #1;
    bad = 0;
    if (kc0 !== 4'hF || kc1 !== 4'hF) bad++;
    repeat (3) begin
      drv_pt();
      if (kc0 !== 4'hF || kc1 !== 4'hF || kp0 !== 4'h0) bad++;
    end
    chk("rstmid_hold", bad == 0, bad, "0");
    rst_n = 1'b1;
    meas("rstmid", 0, 1'b0, 12, 12, 1'b1);

    noisy = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      drv_pt();
      if (c % 64 == 0) noisy = ($urandom_range(0, 1) == 1);
      pad7 = {sw_raw, key_raw};
      for (int ch = 0; ch < 7; ch++)
        if ($urandom_range(0, noisy ? 3 : 40) == 0) pad7[ch] = ~pad7[ch];
      {sw_raw, key_raw} = pad7;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
    end
    rst_n = 1'b1;
    repeat (20) drv_pt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/key_sw_debounce.md
Name: key_sw_debounce

Overview:
- Input-conditioning stage directly upstream of the key/switch local-bus read peripheral.
- Synchronises the raw pad inputs (4 active-low keys, 3 switches) into lb_clk and debounces each channel with a shared tick prescaler.
- Presents clean levels in raw polarity (keys still active-low), so the bus peripheral consumes them unchanged.
- Also emits one-cycle press/release event pulses for a future interrupt or event-latch stage.

Parameters:
- N_KEY, 4, number of key channels.
- N_SW, 3, number of switch channels.
- TICK_DIV, 50000, lb_clk cycles per debounce sample tick; legal range >=1.
- DEBOUNCE_TICKS, 20, consecutive differing ticks required to accept a new level; legal range >=1.

Ports:
- lb_clk  input  1  local-bus clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- key_raw  input  N_KEY  raw key pads, active-low, asynchronous.
- sw_raw  input  N_SW  raw switch pads, asynchronous.
- key_clean  output  N_KEY  debounced key levels, active-low.
- sw_clean  output  N_SW  debounced switch levels.
- key_press  output  N_KEY  one-cycle pulse on debounced 1->0 of a key.
- key_release  output  N_KEY  one-cycle pulse on debounced 0->1 of a key.
- sw_change  output  N_SW  one-cycle pulse on any debounced switch transition.

Behaviour:
- Reset: one clock (lb_clk), asynchronous active-low reset (rst_n); all state is cleared asynchronously on rst_n low and released synchronously to lb_clk.
- Reset values:
  - Key synchronisers and key_clean: all 1 (released).
  - Switch synchronisers and sw_clean: all 0.
  - Prescaler, all per-channel counters, and all pulse outputs: 0.
- Synchroniser: 2-flop per channel. The synced value lags the pad by 2 lb_clk edges.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick is high for the single cycle in which the count equals TICK_DIV-1.
  - TICK_DIV=1 gives tick=1 every cycle.
  - Free-running; never stalled.
- Per-channel debounce:
  - Each channel holds stable (the clean output) and cnt, width clog2(DEBOUNCE_TICKS+1).
  - synced==stable: cnt<=0 every cycle, regardless of tick. Any bounce back fully restarts the window.
  - synced!=stable and tick and cnt<DEBOUNCE_TICKS-1: cnt<=cnt+1.
  - synced!=stable and tick and cnt==DEBOUNCE_TICKS-1: stable<=synced and cnt<=0. The matching event pulse is registered in the same edge, so the pulse is high in the first cycle the new clean level is visible.
  - synced!=stable and no tick: hold.
- Pulse outputs:
  - Asserted for exactly one cycle, then 0.
  - Cannot recur within DEBOUNCE_TICKS ticks on the same channel.
- Latency: from a synced change to the clean update is between (DEBOUNCE_TICKS-1)*TICK_DIV+1 and DEBOUNCE_TICKS*TICK_DIV cycles. Add 2 cycles from the pad.
- Channels are independent. Simultaneous transitions on several channels produce simultaneous pulses in the same cycle.
- Reset mid-count: all counts discarded and outputs return to reset values immediately. After release, a key held low is re-accepted as a fresh press with full latency.
- No glitch path: every output is a flop.

Decomposition:
- Shared package (XT_LBUS_Pkg or a sibling peripheral package):
  - Default TICK_DIV/DEBOUNCE_TICKS constants derived from the SoC clock frequency.
  - Key count and switch count constants.
- Sub-module debounce_chan: 1-bit channel containing the 2-flop synchroniser, counter, stable flop and rise/fall pulses.
  - Parameters: DEBOUNCE_TICKS and RESET_VAL.
  - Input: shared tick.
  - Top level instantiates N_KEY+N_SW copies (keys with RESET_VAL=1, switches with RESET_VAL=0) plus one prescaler.

Test Plan (TICK_DIV=4, DEBOUNCE_TICKS=3 unless stated):
- Reset: rst_n low with key_raw=4'h0 and sw_raw=3'h7 -> key_clean=4'hF, sw_clean=3'h0, all pulses 0 throughout. Release and hold inputs -> key_clean=4'h0 and sw_clean=3'h7 within 2+12 cycles, with key_press=4'hF and sw_change=3'h7 high exactly one cycle.
- Clean press: key_raw[0] 1->0 held -> key_clean[0] falls 11..14 cycles after the pad edge, with key_press[0] high that same single cycle. Release -> key_release[0] one-cycle pulse with the same latency.
- Bounce: key_raw[1] low for 6 cycles, high for 1, then low -> no change before the final low. key_clean[1] falls 11..14 cycles after the last falling edge. Exactly one key_press[1] pulse.
- Short glitch: sw_raw[2] high for 7 cycles then low -> sw_clean stays 0 and sw_change stays 0.
- Simultaneous: key_raw=4'h0 and sw_raw=3'h5 changed on the same cycle -> key_press=4'hF and sw_change=3'h5 asserted together in one cycle.
- Reset mid-count and TICK_DIV=1/DEBOUNCE_TICKS=1:
  - rst_n pulsed low 8 cycles after a key press -> no press pulse and key_clean=4'hF during reset; full latency again after release.
  - With TICK_DIV=1, DEBOUNCE_TICKS=1: key_clean follows the pad with exactly 3 cycles latency.
